// File: rtl/pulse_train_gen.sv
// Per-channel square-wave pulse train generator with programmable half-period and period count.
// Latency: first toggle hp cycles after the start edge; out/busy/done are registered.
// Backpressure: none; start is ignored while running, stop aborts on the next edge.
module pulse_train_gen #(
   parameter int   NUM_CH     = 4,
   parameter int   CNT_W      = 32,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         start,
   input  logic [NUM_CH-1:0]         stop,
   input  logic [NUM_CH*CNT_W-1:0]   half_period,
   input  logic [NUM_CH*CNT_W-1:0]   pulse_count,
   output logic [NUM_CH-1:0]         out,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done
);

   // bit 0 doubles as busy, bit 1 as done
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] hp_q, hp_d;
      logic [CNT_W-1:0] phase_q, phase_d;
      logic [CNT_W:0]   edges_q, edges_d;
      logic             out_q, out_d;
      logic [CNT_W-1:0] hp_raw;
      logic [CNT_W-1:0] hp_cfg;

      // a programmed half-period of 0 would never reload sensibly, so run it as 1
      assign hp_raw = half_period[i*CNT_W +: CNT_W];
      assign hp_cfg = (hp_raw == '0) ? CNT_W'(1) : hp_raw;

      // channel state register; reset abandons any train without flagging done
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= S_IDLE;
            hp_q    <= '0;
            phase_q <= '0;
            edges_q <= '0;
            out_q   <= IDLE_LEVEL;
         end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            phase_q <= phase_d;
            edges_q <= edges_d;
            out_q   <= out_d;
         end
      end

      // next-state: stop dominates everything, start only acts outside RUN
      always_comb begin
         state_d = state_q;
         hp_d    = hp_q;
         phase_d = phase_q;
         edges_d = edges_q;
         out_d   = out_q;
         case (state_q)
            S_RUN: begin
               if (stop[i]) begin
                  state_d = S_IDLE;
                  hp_d    = '0;
                  phase_d = '0;
                  edges_d = '0;
                  out_d   = IDLE_LEVEL;
               end else if (phase_q == '0) begin
                  phase_d = hp_q - CNT_W'(1);
                  if (edges_q == (CNT_W+1)'(1)) begin
                     // last toggle of an even count lands back on the idle level
                     state_d = S_DONE;
                     phase_d = '0;
                     edges_d = '0;
                     out_d   = IDLE_LEVEL;
                  end else begin
                     out_d = ~out_q;
                     // edges_left of 0 means continuous: never count down
                     if (edges_q != '0) begin
                        edges_d = edges_q - (CNT_W+1)'(1);
                     end
                  end
               end else begin
                  phase_d = phase_q - CNT_W'(1);
               end
            end
            default: begin
               if (stop[i]) begin
                  state_d = S_IDLE;
                  hp_d    = '0;
                  phase_d = '0;
                  edges_d = '0;
                  out_d   = IDLE_LEVEL;
               end else if (start[i]) begin
                  state_d = S_RUN;
                  hp_d    = hp_cfg;
                  phase_d = hp_cfg - CNT_W'(1);
                  edges_d = {pulse_count[i*CNT_W +: CNT_W], 1'b0};
                  out_d   = IDLE_LEVEL;
               end
            end
         endcase
      end

      assign out[i]  = out_q;
      assign busy[i] = state_q[0];
      assign done[i] = state_q[1];
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: reset, single and multi-channel trains, strobes and config.
// Expected per-cycle {out,busy,done} comes from a closed-form model of the train timing.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_pulse_train_gen;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;

   logic                    clk;
   logic                    reset;
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       stop;
   logic [NUM_CH*CNT_W-1:0] half_period;
   logic [NUM_CH*CNT_W-1:0] pulse_count;
   logic [NUM_CH-1:0]       out;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       done;

   int vectors;
   int miscompares;

   pulse_train_gen #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .half_period (half_period),
      .pulse_count (pulse_count),
      .out         (out),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {out,busy,done} k cycles after the start edge, for effective half-period hp
   function automatic logic [2:0] exp_state(input int k, input int hp, input int pc);
      if (pc != 0 && k >= 2 * pc * hp) return 3'b001;
      return {((k / hp) % 2) == 1, 1'b1, 1'b0};
   endfunction

   function automatic logic [2:0] obs(input int ch);
      return {out[ch], busy[ch], done[ch]};
   endfunction

   task automatic set_cfg(input int ch, input int hp, input int pc);
      half_period[ch*CNT_W +: CNT_W] = hp;
      pulse_count[ch*CNT_W +: CNT_W] = pc;
   endtask

   task automatic pulse_start(input logic [NUM_CH-1:0] mask);
      start = mask;
      tick();
      start = '0;
   endtask

   // follow channel ch for ncyc cycles after the start edge; optionally poke
   // start/half_period once at cycle poke_k to show they are ignored in RUN
   task automatic follow(input int ch, input int hp, input int pc, input int ncyc,
                         input int poke_k, input logic [NUM_CH-1:0] poke_start,
                         input int poke_hp);
      check($sformatf("ch%0d k0", ch), 12'(obs(ch)), 12'(exp_state(0, hp, pc)));
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         start = '0;
         check($sformatf("ch%0d k%0d", ch, k), 12'(obs(ch)), 12'(exp_state(k, hp, pc)));
         if (k == poke_k) begin
            start = poke_start;
            if (poke_hp >= 0) half_period[ch*CNT_W +: CNT_W] = poke_hp;
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      start       = '0;
      stop        = '0;
      half_period = '0;
      pulse_count = '0;

      // reset state
      tick();
      check("reset_out",  12'(out),  12'h0);
      check("reset_busy", 12'(busy), 12'h0);
      check("reset_done", 12'(done), 12'h0);
      reset = 1'b1;
      tick();

      // CH0 hp=1: toggles every cycle, 2*pc cycles total
      set_cfg(0, 1, 10000);
      pulse_start(4'b0001);
      follow(0, 1, 10000, 20002, -1, 4'b0000, -1);

      // CH1 hp=5 pc=3: rises at 5,15,25, done at 30; start at the DONE-entry edge ignored
      set_cfg(1, 5, 3);
      pulse_start(4'b0010);
      follow(1, 5, 3, 34, 29, 4'b0010, -1);

      // CH2 hp=0 treated as 1: done at 4
      set_cfg(2, 0, 2);
      pulse_start(4'b0100);
      follow(2, 1, 2, 6, -1, 4'b0000, -1);

      // CH2 continuous hp=3, then stop
      set_cfg(2, 3, 0);
      pulse_start(4'b0100);
      follow(2, 3, 0, 1000, -1, 4'b0000, -1);
      stop = 4'b0100;
      tick();
      stop = '0;
      check("ch2_stop", 12'(obs(2)), 12'b000);
      stop = 4'b0100;
      tick();
      stop = '0;
      check("ch2_stop_idle", 12'(obs(2)), 12'b000);

      // CH3 hp=4 pc=1: async reset mid-train, then a clean restart
      set_cfg(3, 4, 1);
      pulse_start(4'b1000);
      for (int k = 1; k <= 6; k++) tick();
      check("ch3_pre_reset", 12'(obs(3)), 12'(exp_state(6, 4, 1)));
      #3;
      reset = 1'b0;
      #1;
      check("async_reset", {out, busy, done}, 12'h0);
      tick();
      reset = 1'b1;
      tick();
      pulse_start(4'b1000);
      follow(3, 4, 1, 10, -1, 4'b0000, -1);

      // all channels together, hp=1..4, pc=2: done at 4, 8, 12, 16
      for (int c = 0; c < NUM_CH; c++) set_cfg(c, c + 1, 2);
      pulse_start(4'b1111);
      for (int k = 1; k <= 18; k++) begin
         tick();
         for (int c = 0; c < NUM_CH; c++)
            check($sformatf("all ch%0d k%0d", c, k), 12'(obs(c)), 12'(exp_state(k, c + 1, 2)));
      end

      // CH0: half_period change plus a second start mid-run leave the timing alone
      set_cfg(0, 2, 3);
      pulse_start(4'b0001);
      follow(0, 2, 3, 14, 3, 4'b0001, 7);
      start = '0;
      check("ch0_done_held", 12'(obs(0)), 12'b001);

      // start and stop together in DONE: stop wins, done clears
      start = 4'b0001;
      stop  = 4'b0001;
      tick();
      start = '0;
      stop  = '0;
      check("ch0_start_stop_done", 12'(obs(0)), 12'b000);
      tick();
      check("ch0_stays_idle", 12'(obs(0)), 12'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
